// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with standard (registered) or first-word-fall-through read, programmable flags and sticky errors.
// Latency: write-to-empty-deassert 1 edge (std) / write-to-visible 2 edges (FWFT); writes dropped when full, reads ignored when empty.
module sync_fifo_fwft #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 32,
    parameter int FWFT_MODE  = 0,
    parameter     RAM_TYPE   = "block",
    localparam int CW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  i_clk,
    input  logic                  i_a_rst_n,
    input  logic                  i_wr_en,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_rd_valid,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [CW-1:0]         o_count,
    input  logic [CW-1:0]         i_prog_full_thr,
    input  logic [CW-1:0]         i_prog_empty_thr,
    output logic                  o_prog_full,
    output logic                  o_prog_empty,
    output logic                  o_overflow,
    output logic                  o_underflow,
    input  logic                  i_clr_err
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;

    logic [DATA_WIDTH-1:0] head_word;
    logic [CW-1:0]         mem_count;
    logic                  full;
    logic                  empty;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  mem_ld;

    // Storage: no reset, asynchronous read of the head word into the output register.
    generate
        if (RAM_TYPE == "distributed") begin : g_dist_ram
            (* ram_style = "distributed" *) logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

            always_ff @(posedge i_clk) begin
                if (wr_acc) begin
                    mem[wr_ptr_q] <= i_wr_data;
                end
            end

            assign head_word = mem[rd_ptr_q];
        end else begin : g_block_ram
            (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

            always_ff @(posedge i_clk) begin
                if (wr_acc) begin
                    mem[wr_ptr_q] <= i_wr_data;
                end
            end

            assign head_word = mem[rd_ptr_q];
        end
    endgenerate

    always_comb begin
        full      = (count_q == CW'(FIFO_DEPTH));
        wr_acc    = i_wr_en & ~full;
        mem_count = count_q;
        empty     = (count_q == '0);
        rd_acc    = 1'b0;
        mem_ld    = 1'b0;

        if (FWFT_MODE != 0) begin
            // The output register is part of the count; the memory holds the rest.
            mem_count = count_q - CW'(rd_valid_q);
            empty     = ~rd_valid_q;
            rd_acc    = i_rd_en & rd_valid_q;
            mem_ld    = (~rd_valid_q | rd_acc) & (mem_count != '0);
        end else begin
            rd_acc    = i_rd_en & ~empty;
            mem_ld    = rd_acc;
        end
    end

    always_comb begin
        wr_ptr_d  = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = mem_ld ? rd_ptr_q + AW'(1) : rd_ptr_q;
        rd_data_d = mem_ld ? head_word : rd_data_q;

        if (FWFT_MODE != 0) begin
            rd_valid_d = mem_ld | (rd_valid_q & ~rd_acc);
        end else begin
            rd_valid_d = rd_acc;
        end

        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // A new error event on the clearing edge keeps the flag set.
        ovf_d = (i_wr_en & full) | (ovf_q & ~i_clr_err);
        unf_d = (i_rd_en & empty) | (unf_q & ~i_clr_err);
    end

    always_ff @(posedge i_clk or negedge i_a_rst_n) begin
        if (!i_a_rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    assign o_rd_data    = rd_data_q;
    assign o_rd_valid   = rd_valid_q;
    assign o_full       = full;
    assign o_empty      = empty;
    assign o_count      = count_q;
    assign o_overflow   = ovf_q;
    assign o_underflow  = unf_q;
    assign o_prog_full  = (i_prog_full_thr != '0) && (count_q >= i_prog_full_thr);
    assign o_prog_empty = (count_q <= i_prog_empty_thr);

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Drives one standard-mode and one FWFT-mode FIFO with shared stimulus and checks both against queue models.
module tb_sync_fifo_fwft;

    localparam int DW = 8;
    localparam int D  = 32;
    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en = 1'b0;
    logic          clr = 1'b0;
    logic [CW-1:0] pf_thr = CW'(28);
    logic [CW-1:0] pe_thr = CW'(3);

    logic [DW-1:0] s_rd_data, f_rd_data;
    logic          s_rd_valid, f_rd_valid, s_full, f_full, s_empty, f_empty;
    logic [CW-1:0] s_count, f_count;
    logic          s_pfull, f_pfull, s_pempty, f_pempty, s_ovf_o, f_ovf_o, s_unf_o, f_unf_o;

    sync_fifo_fwft #(.DATA_WIDTH(DW), .FIFO_DEPTH(D), .FWFT_MODE(0), .RAM_TYPE("block")) u_std (
        .i_clk(clk), .i_a_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_data(wr_data), .i_rd_en(rd_en),
        .o_rd_data(s_rd_data), .o_rd_valid(s_rd_valid), .o_full(s_full), .o_empty(s_empty),
        .o_count(s_count), .i_prog_full_thr(pf_thr), .i_prog_empty_thr(pe_thr),
        .o_prog_full(s_pfull), .o_prog_empty(s_pempty), .o_overflow(s_ovf_o),
        .o_underflow(s_unf_o), .i_clr_err(clr)
    );

    sync_fifo_fwft #(.DATA_WIDTH(DW), .FIFO_DEPTH(D), .FWFT_MODE(1), .RAM_TYPE("distributed")) u_fwft (
        .i_clk(clk), .i_a_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_data(wr_data), .i_rd_en(rd_en),
        .o_rd_data(f_rd_data), .o_rd_valid(f_rd_valid), .o_full(f_full), .o_empty(f_empty),
        .o_count(f_count), .i_prog_full_thr(pf_thr), .i_prog_empty_thr(pe_thr),
        .o_prog_full(f_pfull), .o_prog_empty(f_pempty), .o_overflow(f_ovf_o),
        .o_underflow(f_unf_o), .i_clr_err(clr)
    );

    always #5 clk = ~clk;

    // Standard model: queue of stored words, registered read result.
    logic [DW-1:0] sq[$];
    logic [DW-1:0] s_dat;
    logic          s_vld, s_ovf, s_unf;
    // FWFT model: each word carries the edge it was written on; the head is
    // visible once at least one further edge has passed.
    logic [DW-1:0] fq[$];
    int            fe[$];
    logic          f_vld, f_ovf, f_unf;

    int edge_n = 0;
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int ss = sq.size();
        int fs = fq.size();
        chk("s_count",   32'(s_count),    32'(ss));
        chk("s_empty",   32'(s_empty),    32'(ss == 0));
        chk("s_full",    32'(s_full),     32'(ss == D));
        chk("s_valid",   32'(s_rd_valid), 32'(s_vld));
        chk("s_data",    32'(s_rd_data),  32'(s_dat));
        chk("s_ovf",     32'(s_ovf_o),    32'(s_ovf));
        chk("s_unf",     32'(s_unf_o),    32'(s_unf));
        chk("s_pfull",   32'(s_pfull),    32'(pf_thr != 0 && ss >= int'(pf_thr)));
        chk("s_pempty",  32'(s_pempty),   32'(ss <= int'(pe_thr)));
        chk("f_count",   32'(f_count),    32'(fs));
        chk("f_empty",   32'(f_empty),    32'(!f_vld));
        chk("f_full",    32'(f_full),     32'(fs == D));
        chk("f_valid",   32'(f_rd_valid), 32'(f_vld));
        if (f_vld) chk("f_data", 32'(f_rd_data), 32'(fq[0]));
        chk("f_ovf",     32'(f_ovf_o),    32'(f_ovf));
        chk("f_unf",     32'(f_unf_o),    32'(f_unf));
        chk("f_pfull",   32'(f_pfull),    32'(pf_thr != 0 && fs >= int'(pf_thr)));
        chk("f_pempty",  32'(f_pempty),   32'(fs <= int'(pe_thr)));
    endtask

    task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
        logic s_wacc, s_racc, s_oset, s_uset, f_wacc, f_pop, f_oset, f_uset;
        wr_en = w; wr_data = d; rd_en = r; clr = c;
        s_wacc = w && (sq.size() < D);
        s_racc = r && (sq.size() > 0);
        s_oset = w && (sq.size() == D);
        s_uset = r && (sq.size() == 0);
        f_wacc = w && (fq.size() < D);
        f_pop  = r && f_vld;
        f_oset = w && (fq.size() == D);
        f_uset = r && !f_vld;
        @(posedge clk);
        edge_n++;
        s_vld = s_racc;
        if (s_racc) s_dat = sq.pop_front();
        if (s_wacc) sq.push_back(d);
        s_ovf = s_oset | (s_ovf & ~c);
        s_unf = s_uset | (s_unf & ~c);
        if (f_pop) begin
            void'(fq.pop_front());
            void'(fe.pop_front());
        end
        if (f_wacc) begin
            fq.push_back(d);
            fe.push_back(edge_n);
        end
        f_vld = 1'b0;
        if (fq.size() > 0) f_vld = (fe[0] < edge_n);
        f_ovf = f_oset | (f_ovf & ~c);
        f_unf = f_uset | (f_unf & ~c);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
        rst_n = 1'b0;
        sq.delete(); fq.delete(); fe.delete();
        s_dat = '0; s_vld = 1'b0; s_ovf = 1'b0; s_unf = 1'b0;
        f_vld = 1'b0; f_ovf = 1'b0; f_unf = 1'b0;
        #2;
        check_all();
        chk("rst_s_count", 32'(s_count), 32'd0);
        chk("rst_f_empty", 32'(f_empty), 32'd1);
        chk("rst_f_valid", 32'(f_rd_valid), 32'd0);
        chk("rst_f_data",  32'(f_rd_data), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check_all();
    endtask

    initial begin
        int wp, rp;
        #2;
        do_reset();

        // Fill 0..31 with threshold checks at 27 and 28 words.
        for (int i = 0; i < D; i++) begin
            step(1'b1, DW'(i), 1'b0, 1'b0);
            if (i == 26) begin
                chk("pfull_at_27_s", 32'(s_pfull), 32'd0);
                chk("pfull_at_27_f", 32'(f_pfull), 32'd0);
            end
            if (i == 27) begin
                chk("pfull_at_28_s", 32'(s_pfull), 32'd1);
                chk("pfull_at_28_f", 32'(f_pfull), 32'd1);
            end
        end
        chk("full_s", 32'(s_full), 32'd1);
        chk("full_count_f", 32'(f_count), 32'd32);
        step(1'b1, 8'hEE, 1'b0, 1'b0);
        chk("ovf_s", 32'(s_ovf_o), 32'd1);
        chk("ovf_count_s", 32'(s_count), 32'd32);

        pf_thr = '0;
        #1;
        check_all();
        chk("pfull_disabled", 32'(s_pfull), 32'd0);
        pf_thr = CW'(28);

        // Write and read together while full: write dropped, oldest word read.
        step(1'b1, 8'h77, 1'b1, 1'b0);
        chk("wr_rd_full_s_data", 32'(s_rd_data), 32'd0);
        chk("wr_rd_full_ovf_f", 32'(f_ovf_o), 32'd1);
        step(1'b0, '0, 1'b0, 1'b1);

        // Drain in order; the model checks every word.
        for (int i = 0; i < D - 1; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            if (sq.size() == 3) chk("pempty_at_3", 32'(s_pempty), 32'd1);
        end
        chk("drained_empty_s", 32'(s_empty), 32'd1);

        // Underflow, and a clear on the same edge as a new underflow.
        step(1'b0, '0, 1'b1, 1'b0);
        chk("unf_set", 32'(s_unf_o), 32'd1);
        step(1'b0, '0, 1'b1, 1'b1);
        chk("unf_set_wins", 32'(f_unf_o), 32'd1);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("unf_cleared", 32'(s_unf_o), 32'd0);

        // FWFT write-to-visible latency.
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        chk("fwft_lat_n", 32'(f_rd_valid), 32'd0);
        step(1'b0, '0, 1'b0, 1'b0);
        chk("fwft_lat_n1_vld", 32'(f_rd_valid), 32'd1);
        chk("fwft_lat_n1_dat", 32'(f_rd_data), 32'hA5);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("fwft_pop_empty", 32'(f_empty), 32'd1);
        chk("fwft_pop_count", 32'(f_count), 32'd0);

        // Simultaneous traffic around count 5 across pointer wrap.
        for (int i = 0; i < 5; i++) step(1'b1, DW'(8'h40 + i), 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) step(1'b1, DW'($urandom), 1'b1, 1'b0);
        chk("steady_count_s", 32'(s_count), 32'd5);
        chk("steady_count_f", 32'(f_count), 32'd5);

        // Reset asserted mid-stream.
        for (int i = 0; i < 3; i++) step(1'b1, DW'($urandom), 1'b1, 1'b0);
        do_reset();

        // Randomised traffic with drifting bias, threshold changes and clears.
        for (int i = 0; i < 1200; i++) begin
            if (i % 150 == 0) begin
                wp = $urandom_range(20, 90);
                rp = $urandom_range(20, 90);
                pf_thr = CW'($urandom_range(0, 33));
                pe_thr = CW'($urandom_range(0, 33));
            end
            step(($urandom_range(0, 99) < wp), DW'($urandom), ($urandom_range(0, 99) < rp),
                 ($urandom_range(0, 99) < 5));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
